// File: rtl/display_pkg.sv
// Shared encodings for the 7-segment scan controller: display modes, fixed glyphs
// and the hex glyph table (active-low, bit order {g,f,e,d,c,b,a}).
package display_pkg;

  typedef enum logic [2:0] {
    MODE_ERR   = 3'b001,
    MODE_CODE  = 3'b010,
    MODE_BLANK = 3'b100
  } mode_e;

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    return HEX_GLYPH[value];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = hex_glyph(hex_i);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous input shadowing.
// Define DISPLAY_BLINK_EN to blink the Err message every BLINK_FRAMES frames.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   entered_code,
  input  logic [2:0]                display_mode,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_err
    $error("display_scan_ctrl: illegal parameter set");
  end

  logic [CNT_W-1:0]          scan_cnt_q, scan_cnt_d;
  logic [DIG_W-1:0]          digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0]   code_q, code_d;
  logic [2:0]                mode_q, mode_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;

  logic                      scan_last;
  logic                      frame_end;
  logic [4*NUM_DIGITS-1:0]   code_shift;
  logic [3:0]                hex_nib;
  logic [6:0]                hex_seg;
  logic [6:0]                err_seg;
  logic [NUM_DIGITS-1:0]     an_sel;
  logic                      blink_dark;

  assign scan_last  = (scan_cnt_q == CNT_LAST);
  assign frame_end  = scan_last && (digit_q == DIG_LAST);
  assign frame_tick = frame_end;

  // Counters and frame-boundary shadow capture
  always_comb begin
    scan_cnt_d = scan_last ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_last) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
    code_d = code_q;
    mode_d = mode_q;
    if (frame_end) begin
      code_d = entered_code;
      mode_d = display_mode;
    end
  end

  assign code_shift = code_q >> {digit_q, 2'b00};
  assign hex_nib    = code_shift[3:0];
  assign an_sel     = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_q);

  seg7_decoder u_seg7_decoder (
    .hex_i   (hex_nib),
    .seg_n_o (hex_seg)
  );

  // "Err" occupies the three most significant digits; anything below stays dark.
  always_comb begin
    err_seg = SEG_BLANK;
    if (digit_q == DIG_LAST) begin
      err_seg = SEG_E;
    end else if (int'(digit_q) == NUM_DIGITS - 2 || int'(digit_q) == NUM_DIGITS - 3) begin
      err_seg = SEG_R;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_q, blink_d;

  // A mode change restarts the blink cycle in the lit phase.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      if (display_mode != mode_q) begin
        frame_cnt_d = '0;
        blink_d     = 1'b0;
      end else if (frame_cnt_q == BF_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_dark = blink_q;
`else
  assign blink_dark = 1'b0;
`endif

  // Output slot for the digit currently selected, registered one cycle later
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    case (mode_q)
      MODE_CODE: begin
        seg_d = hex_seg;
        an_d  = an_sel;
      end
      MODE_ERR: begin
        seg_d = err_seg;
        an_d  = blink_dark ? '1 : an_sel;
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      code_q     <= '0;
      mode_q     <= MODE_BLANK;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      code_q     <= code_d;
      mode_q     <= mode_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl, checked against a
// frame-level reference model built from the recorded input history.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;
  localparam int HIST  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] entered_code;
  logic [2:0]  display_mode;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entered_code (entered_code),
    .display_mode (display_mode),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  logic [15:0] hist_code [HIST];
  logic [2:0]  hist_mode [HIST];

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, got, exp);
    end
  endtask

  // Frame f is displayed with what was on the inputs in the last cycle of frame f-1.
  function automatic logic [2:0] mode_of(input int f);
    return (f == 0) ? 3'b100 : hist_mode[FRAME*f - 1];
  endfunction

  function automatic logic [15:0] code_of(input int f);
    return (f == 0) ? 16'h0000 : hist_code[FRAME*f - 1];
  endfunction

  // Blink is dark in every second group of BF frames since the mode last changed.
  function automatic bit blink_dark(input int f);
    int g = f;
    while (g > 0 && mode_of(g - 1) == mode_of(f)) g--;
    return (((f - g) / BF) % 2) == 1;
  endfunction

  task automatic check_cycle();
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic [15:0] sh;
    logic [3:0]  one;
    int s, f, d;
    one     = 4'b0001;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    if (t > 0) begin
      s = t - 1;
      f = s / FRAME;
      d = (s / SD) % ND;
      case (mode_of(f))
        3'b010: begin
          sh      = code_of(f) >> (4 * d);
          exp_seg = glyph[sh[3:0]];
          exp_an  = ~(one << d);
        end
        3'b001: begin
          exp_seg = (d == ND - 1) ? 7'b0000110 : ((d >= ND - 3) ? 7'b0101111 : 7'h7F);
          exp_an  = ~(one << d);
`ifdef DISPLAY_BLINK_EN
          if (blink_dark(f)) exp_an = 4'hF;
`endif
        end
        default: begin
          exp_seg = 7'h7F;
          exp_an  = 4'hF;
        end
      endcase
    end
    chk("seg_n", 32'(seg_n), 32'(exp_seg));
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("frame_tick", 32'(frame_tick), 32'((t % FRAME) == FRAME - 1));
  endtask

  task automatic tick();
    hist_code[t] = entered_code;
    hist_mode[t] = display_mode;
    @(posedge clk);
    #1;
    t++;
    if (t >= HIST) begin
      $display("FAIL history_bound: t=%0d exceeds %0d", t, HIST);
      $fatal(1, "history overflow");
    end
    check_cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_seg_n", 32'(seg_n), 32'h7F);
      chk("rst_an_n", 32'(an_n), 32'hF);
      chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    end
    rst_n = 1'b1;
    t = 0;
  endtask

  initial begin
    rst_n        = 1'b0;
    display_mode = 3'b010;
    entered_code = 16'h9070;
    do_reset(3);

    // Blank first frame, then 9070 in code mode
    repeat (4 * FRAME) tick();

    // Err, long enough to cover several blink windows
    display_mode = 3'b001;
    repeat (7 * FRAME) tick();

    // Non-one-hot modes stay dark
    display_mode = 3'b111;
    entered_code = 16'hAAAA;
    repeat (2 * FRAME) tick();
    display_mode = 3'b000;
    repeat (2 * FRAME) tick();

    // Mid-frame code change must not tear the current frame
    display_mode = 3'b010;
    entered_code = 16'h1234;
    repeat (FRAME) tick();
    while (t % FRAME != 8) tick();
    entered_code = 16'h5678;
    repeat (2 * FRAME) tick();

    // One-cycle reset while digit 2 is being scanned
    while (t % FRAME != 9) tick();
    do_reset(1);
    repeat (3 * FRAME) tick();

    // Randomized inputs, including illegal mode codes
    repeat (600) begin
      if ($urandom_range(0, 59) == 0) display_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) entered_code = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
